// File: rtl/lutram_test_pkg.sv
// Shared types and helpers for the LUTRAM read-back checker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lutram_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The write side stores the address LSB, optionally inverted, so the read
    // side only needs that one address bit to know what to expect.
    function automatic logic expected_bit(input logic addr_lsb, input logic invert);
        return addr_lsb ^ invert;
    endfunction

    // Increment that sticks at max instead of wrapping. Callers zero-extend
    // their counter into 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
        return (value >= max) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/lutram_readback_checker_led_blinker.sv
// Status LED driver: solid when 'solid', blinking when 'blink', dark otherwise.
// Latency: led follows solid combinationally; the first blink toggle comes 2**BLINK_DIV_WIDTH cycles after en rises.
// Backpressure: none; free-running while en is high.
//
// Ports: clk_i/rst_ni clock and async active-low reset; en runs the divider
// (low holds it and the blink phase at 0); solid/blink select the LED mode.
module led_blinker #(
    parameter int BLINK_DIV_WIDTH = 24
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic solid,
    input  logic blink,
    output logic led
);

    logic [BLINK_DIV_WIDTH-1:0] div_cnt_q;
    logic                       blink_q;

    // The divider restarts from 0 whenever en drops, so every DONE episode
    // sees the same first-toggle delay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else if (!en) begin
            div_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_q + BLINK_DIV_WIDTH'(1);
            if (&div_cnt_q) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign led = solid | (blink & blink_q);

endmodule

// File: rtl/lutram_readback_checker.sv
// Checks the LUTRAM read-back stream against the expected pattern and reports a pass/fail verdict plus LED.
// Latency: err_cnt_o and the verdict update on the clk_i edge that captures the sample (1 cycle).
// Backpressure: none; accepts a sample every cycle, ignores samples once the verdict is out.
//
// Ports: clk_i, rst_ni (async active-low); clear_i restarts the test;
// sample_i/addr_i/q_i/last_i carry the read-back stream; done_o/pass_o/fail_o
// give the verdict; err_cnt_o the saturating mismatch count; led_o the status LED.
// Optional build macro FIRST_ERR_ADDR_EN adds first_err_o/first_err_addr_o,
// which capture the address of the first mismatch since reset/clear.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH         = 7,
    parameter int ERR_CNT_WIDTH   = 8,
    parameter int BLINK_DIV_WIDTH = 24,
    parameter int INVERT          = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     sample_i,
    input  logic [A_WIDTH-1:0]       addr_i,
    input  logic                     q_i,
    input  logic                     last_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     led_o
`ifdef FIRST_ERR_ADDR_EN
    ,
    output logic [A_WIDTH-1:0]       first_err_addr_o,
    output logic                     first_err_o
`endif
);

    localparam int                 SCNT_W     = A_WIDTH + 1;
    localparam logic               INVERT_BIT = (INVERT != 0);
    localparam logic [31:0]        SCNT_MAX   = 32'({SCNT_W{1'b1}});
    localparam logic [31:0]        ERR_MAX    = 32'({ERR_CNT_WIDTH{1'b1}});
    localparam logic [SCNT_W-1:0]  SCNT_FULL  = {1'b1, {A_WIDTH{1'b0}}};

    state_t                    state_q, state_d;
    logic [SCNT_W-1:0]         sample_cnt_q, sample_cnt_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                      pass_q;
    logic                      accept;
    logic                      mismatch;
    logic                      pass_next;
    logic                      in_done;
    logic                      blink_en, blink_solid, blink_fail;

    // clear_i wins over a coincident sample; DONE ignores samples entirely.
    assign accept    = sample_i && !clear_i && (state_q != DONE);
    assign mismatch  = sample_i && (q_i != expected_bit(addr_i[0], INVERT_BIT));

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (accept) begin
            sample_cnt_d = SCNT_W'(sat_inc(32'(sample_cnt_q), SCNT_MAX));
            if (mismatch) begin
                err_cnt_d = ERR_CNT_WIDTH'(sat_inc(32'(err_cnt_q), ERR_MAX));
            end
        end
    end

    // Verdict is taken from the next-count values so the final sample counts.
    assign pass_next = (err_cnt_d == '0) && (sample_cnt_d == SCNT_FULL);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, CHECK: begin
                    if (sample_i) begin
                        state_d = last_i ? DONE : CHECK;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        in_done     = (state_q == DONE);
        done_o      = in_done;
        pass_o      = in_done && pass_q;
        fail_o      = in_done && !pass_q;
        // Dropping en during clear_i zeroes the divider on the clearing edge.
        blink_en    = in_done && !clear_i;
        blink_solid = in_done && pass_q;
        blink_fail  = in_done && !pass_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            pass_q       <= 1'b0;
        end else if (clear_i) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            pass_q       <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            if (accept && last_i) begin
                pass_q <= pass_next;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;

`ifdef FIRST_ERR_ADDR_EN
    logic [A_WIDTH-1:0] first_err_addr_q;
    logic               first_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_err_addr_q <= '0;
            first_err_q      <= 1'b0;
        end else if (clear_i) begin
            first_err_addr_q <= '0;
            first_err_q      <= 1'b0;
        end else if (accept && mismatch && !first_err_q) begin
            first_err_addr_q <= addr_i;
            first_err_q      <= 1'b1;
        end
    end

    assign first_err_addr_o = first_err_addr_q;
    assign first_err_o      = first_err_q;
`else
    // Only the address LSB feeds the compare when the capture is absent.
    logic unused_addr;
    assign unused_addr = ^addr_i;
`endif

    led_blinker #(
        .BLINK_DIV_WIDTH (BLINK_DIV_WIDTH)
    ) u_led_blinker (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (blink_en),
        .solid  (blink_solid),
        .blink  (blink_fail),
        .led    (led_o)
    );

endmodule
